// File: rtl/sampler_pkg.sv
// Shared types and constants for the delay-chain launch/capture sampler.
package sampler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_SETTLE,
        S_DONE
    } state_e;

    localparam int unsigned CAPT_GAP_MAX = 15;
    localparam int unsigned SETTLE_MAX   = 255;
    // Wide enough to hold SETTLE_MAX-1 and CAPT_GAP_MAX-1
    localparam int unsigned TIMER_W      = 8;

endpackage

// File: rtl/sampler_timer.sv
// Loadable down-counter shared by the WAIT and SETTLE phases; o_tc_c flags zero.
module sampler_timer
    import sampler_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_tc_c
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_tc_c = (r_count == '0);

endmodule

// File: rtl/delay_chain_sampler.sv
// Launches an edge into a spy delay chain, captures its output CAPT_GAP edges
// later and counts trials whose capture missed the settled value.
module delay_chain_sampler
    import sampler_pkg::*;
#(
    parameter int unsigned TRIAL_W    = 16,
    parameter int unsigned CAPT_GAP   = 1,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned INVERT     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TRIAL_W-1:0] num_trials,
    output logic               path_launch,   // to chain pathInput
    input  logic               path_result,   // from chain pathResult
    output logic               busy,
    output logic               done,
    output logic [TRIAL_W-1:0] err_count,
    output logic [TRIAL_W-1:0] trial_count,
    output logic               last_sample
);

    if (CAPT_GAP < 1 || CAPT_GAP > CAPT_GAP_MAX) begin : g_bad_capt_gap
        $error("delay_chain_sampler: CAPT_GAP out of range");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > SETTLE_MAX) begin : g_bad_settle
        $error("delay_chain_sampler: SETTLE_CYC out of range");
    end

    localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(CAPT_GAP - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYC - 1);
    localparam logic               INV_BIT     = 1'(INVERT);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_val;
    logic               w_tmr_tc;
    logic               w_expected;

    logic               r_path_launch;
    logic               r_busy;
    logic               r_done;
    logic [TRIAL_W-1:0] r_err_count;
    logic [TRIAL_W-1:0] r_trial_count;
    logic [TRIAL_W-1:0] r_num_trials;
    logic               r_last_sample;
    // Capture flop for the asynchronous chain output; resolved for a cycle before use
    (* async_reg = "true" *) logic r_sample_q;

    sampler_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc_c     (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_trials != '0) ? S_LAUNCH : S_DONE;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_val   = GAP_LOAD;
            end
            S_WAIT: begin
                if (w_tmr_tc) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_SETTLE;
                w_tmr_load  = 1'b1;
                w_tmr_val   = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (w_tmr_tc) begin
                    w_state_nxt = (r_trial_count < r_num_trials) ? S_LAUNCH : S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_expected = r_path_launch ^ INV_BIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_path_launch <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_count   <= '0;
            r_trial_count <= '0;
            r_num_trials  <= '0;
            r_last_sample <= 1'b0;
            r_sample_q    <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_trials  <= num_trials;
                        r_err_count   <= '0;
                        r_trial_count <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_path_launch <= ~r_path_launch;
                end
                S_WAIT: begin
                    if (w_tmr_tc) begin
                        r_sample_q <= path_result;
                    end
                end
                S_CHECK: begin
                    if (r_sample_q != w_expected) begin
                        r_err_count <= r_err_count + TRIAL_W'(1);
                    end
                    r_trial_count <= r_trial_count + TRIAL_W'(1);
                    r_last_sample <= r_sample_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign path_launch = r_path_launch;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_count   = r_err_count;
    assign trial_count = r_trial_count;
    assign last_sample = r_last_sample;

endmodule
